sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single external 16-bit SRAM between two byte-wide requesters: port A (CPU core) and port B (config/video side, e.g. persisting the video-config byte).
- Port selection is round-robin. Each access is sequenced with fixed setup, strobe and hold timing.
- A 21-bit byte address maps onto the 20-bit word SRAM. Bit 20 selects the upper or lower byte lane.
- Sits between the core/config logic and the top-level tristate pad logic; it drives data_out/data_oe and never an inout.

Parameters:
- ADDR_SETUP, 1: cycles of address/lane setup before a strobe (1..15).
- READ_WAIT, 2: cycles oe_n is held low; read data is captured on the last of these (1..15).
- WE_PULSE, 2: cycles we_n is held low for a write (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- bus_hold  in  1  when high, no new access is granted; an access already in progress completes
- a_req  in  1  port A request (level)
- a_we  in  1  port A: 1 = write, 0 = read
- a_addr  in  21  port A byte address
- a_wdata  in  8  port A write byte
- a_ack  out  1  port A one-cycle completion pulse
- a_rdata  out  8  port A read byte
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as port A, for port B
- sram_addr  out  20  word address
- sram_we_n  out  1  write strobe, active-low
- sram_oe_n  out  1  output enable, active-low
- sram_ub_n  out  1  upper-byte lane, active-low
- sram_lb_n  out  1  lower-byte lane, active-low
- sram_data_out  out  16  write data, {wdata, wdata}
- sram_data_oe  out  1  pad driver enable
- sram_data_in  in  16  data bus as sampled at the pads

Behaviour:
- Reset (async, active-high; the rst condition takes effect at once, even mid-access):
  - outputs: sram_we_n=1, oe_n=1, ub_n=1, lb_n=1, data_oe=0, sram_addr=0, both acks 0, both rdata 0
  - FSM = IDLE, round-robin pointer = A
  - an access interrupted by reset is abandoned with no ack
- FSM states: IDLE, SETUP, ACCESS, HOLD, DONE. A 4-bit down-counter times SETUP and ACCESS.
- IDLE:
  - if bus_hold=0 and any req is high, grant: a single requester wins; if both request, the port not granted last wins.
  - latch the granted port's we, addr and wdata; go to SETUP. All SRAM-side outputs then come from the latched values only.
- Lane select, from latched addr[20]:
  - 1: ub_n=0, lb_n=1, read byte = data_in[15:8]
  - 0: ub_n=1, lb_n=0, read byte = data_in[7:0]
  - sram_addr = addr[19:0].
  - Lane strobes are active from SETUP through HOLD (or through ACCESS for reads); they are 1 in IDLE and DONE.
- SETUP (ADDR_SETUP cycles): we_n=1, oe_n=1. For writes, data_oe=1 from here on. Then go to ACCESS.
- ACCESS, read: oe_n=0 for READ_WAIT cycles. data_in is captured on the last ACCESS cycle into the granted port's rdata. Then go to DONE.
- ACCESS, write: we_n=0 for WE_PULSE cycles, then go to HOLD.
- HOLD: write only, 1 cycle; we_n=1, data_oe and lanes still asserted, so data and address are held past the rising edge of we_n.
- DONE: 1 cycle.
  - granted ack=1, all strobes deasserted, data_oe=0.
  - round-robin pointer records the granted port; go to IDLE.
- Latency, counted from req high in IDLE at cycle 0 to the ack cycle:
  - read: 1+ADDR_SETUP+READ_WAIT (4 with defaults)
  - write: 2+ADDR_SETUP+WE_PULSE (5 with defaults)
  - IDLE always costs one cycle between accesses.
- Handshake:
  - req is held until ack. The requester must drop req, or present a new request, in the cycle after ack.
  - req is sampled only in IDLE, so changes at other times are ignored.
  - rdata holds its value until that port's next read completes.
  - acks are never asserted simultaneously.
- bus_hold:
  - rising mid-access: the access runs to DONE, then the FSM stays in IDLE with all outputs inactive.
  - falling: grant on the next IDLE cycle.
- Write data and oe_n are never active together: oe_n=1 throughout every write, and data_oe=0 throughout every read.

Decomposition:
- Shared package sram_arb_pkg:
  - state enum (IDLE/SETUP/ACCESS/HOLD/DONE)
  - port-index constants PORT_A=0, PORT_B=1
  - function lane_sel(addr20) returning {ub_n, lb_n}
  - counter width constant CNT_W=4
- One sub-module, sram_rr_picker: combinational grant from {a_req, b_req, last_grant}. It outputs grant_valid and grant_idx and is testable alone.

Test Plan:
- Reset: hold rst=1 → all strobes high, data_oe=0, acks 0. Release, then A reads 0x08FD5 with data_in=0x5A3C → lb_n=0, ub_n=1, sram_addr=0x08FD5, oe_n low in cycles 2-3, a_ack in cycle 4, a_rdata=0x3C.
- Upper-lane write: B writes 0x1_00010 with data 0xA7 → ub_n=0, lb_n=1, sram_data_out=0xA7A7, data_oe cycles 1-4, we_n low cycles 2-3 only, b_ack cycle 5.
- Contention: a_req and b_req both high continuously, after reset (pointer=A) → grant order B, A, B, A; each ack is single-cycle and the acks never overlap.
- bus_hold: assert bus_hold in cycle 2 of an A write → write completes with a_ack in cycle 5. A pending b_req is not served until bus_hold=0, then b_ack arrives 1+ADDR_SETUP+READ_WAIT cycles later.
- Reset mid-write: assert rst while we_n=0 → we_n=1, data_oe=0 immediately (async). No ack. After release, the FSM is IDLE and the pointer is A.
- Parameters ADDR_SETUP=3, READ_WAIT=4, WE_PULSE=1 → read ack at cycle 8, write ack at cycle 6, oe_n low exactly 4 cycles, we_n low exactly 1 cycle.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the two-port SRAM arbiter: FSM states,
// port indices and the byte-lane decode.
package sram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    DONE
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  localparam int   CNT_W  = 4;

  // Returns {ub_n, lb_n}; byte-address bit 20 picks the upper lane.
  function automatic logic [1:0] lane_sel(input logic addr20);
    return addr20 ? 2'b01 : 2'b10;
  endfunction

endpackage

// File: rtl/sram_rr_picker.sv
// Combinational round-robin pick between port A and port B; on contention
// the port that was not granted last wins.
module sram_rr_picker
  import sram_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_idx
);

  // NOTE: every output gets a default first so no path through the block
  // leaves it unassigned, which is what keeps this combinational (no latch).
  always_comb begin
    grant_valid = a_req | b_req;
    grant_idx   = PORT_A;
    if (a_req && b_req) begin
      grant_idx = ~last_grant;
    end else if (b_req) begin
      grant_idx = PORT_B;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one 16-bit asynchronous SRAM between two byte-wide requesters with
// round-robin grant and fixed setup / strobe / hold sequencing.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_SETUP = 1,
  parameter int READ_WAIT  = 2,
  parameter int WE_PULSE   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_hold,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [20:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic        a_ack,
  output logic [7:0]  a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [20:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic        b_ack,
  output logic [7:0]  b_rdata,
  output logic [19:0] sram_addr,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  output logic [15:0] sram_data_out,
  output logic        sram_data_oe,
  input  logic [15:0] sram_data_in
);

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(ADDR_SETUP - 1);
  localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WE_LOAD    = CNT_W'(WE_PULSE - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gnt_q;
  logic             last_q;
  logic             we_q;
  logic [20:0]      addr_q;
  logic [7:0]       wdata_q;
  logic             grant_valid;
  logic             grant_idx;
  logic             grant_now;
  logic [7:0]       rd_byte;

  sram_rr_picker u_picker (
    .a_req      (a_req),
    .b_req      (b_req),
    .last_grant (last_q),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx)
  );

  assign grant_now = (state_q == IDLE) && !bus_hold && grant_valid;
  assign rd_byte   = addr_q[20] ? sram_data_in[15:8] : sram_data_in[7:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (grant_now) begin
          state_d = SETUP;
          cnt_d   = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = ACCESS;
          cnt_d   = we_q ? WE_LOAD : READ_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = we_q ? HOLD : DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes decode from state and latched request only, so an async reset
  // drops them in the same instant it forces IDLE.
  always_comb begin
    sram_we_n    = 1'b1;
    sram_oe_n    = 1'b1;
    sram_ub_n    = 1'b1;
    sram_lb_n    = 1'b1;
    sram_data_oe = 1'b0;
    a_ack        = 1'b0;
    b_ack        = 1'b0;
    case (state_q)
      SETUP: begin
        {sram_ub_n, sram_lb_n} = lane_sel(addr_q[20]);
        sram_data_oe           = we_q;
      end
      ACCESS: begin
        {sram_ub_n, sram_lb_n} = lane_sel(addr_q[20]);
        sram_data_oe           = we_q;
        sram_we_n              = ~we_q;
        sram_oe_n              = we_q;
      end
      HOLD: begin
        {sram_ub_n, sram_lb_n} = lane_sel(addr_q[20]);
        sram_data_oe           = 1'b1;
      end
      DONE: begin
        a_ack = (gnt_q == PORT_A);
        b_ack = (gnt_q == PORT_B);
      end
      default: ;
    endcase
  end

  assign sram_addr     = addr_q[19:0];
  assign sram_data_out = {wdata_q, wdata_q};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= PORT_A;
      last_q  <= PORT_A;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant_now) begin
        gnt_q   <= grant_idx;
        we_q    <= (grant_idx == PORT_B) ? b_we    : a_we;
        addr_q  <= (grant_idx == PORT_B) ? b_addr  : a_addr;
        wdata_q <= (grant_idx == PORT_B) ? b_wdata : a_wdata;
      end
      if (state_q == ACCESS && cnt_q == '0 && !we_q) begin
        if (gnt_q == PORT_B) b_rdata <= rd_byte;
        else                 a_rdata <= rd_byte;
      end
      if (state_q == DONE) last_q <= gnt_q;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: default timing instance plus a second
// instance with ADDR_SETUP=3, READ_WAIT=4, WE_PULSE=1.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_hold;
  logic        a_req, a_we, b_req, b_we;
  logic [20:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic [15:0] data_in;
  logic        a_ack, b_ack;
  logic [7:0]  a_rdata, b_rdata;
  logic [19:0] sram_addr;
  logic        we_n, oe_n, ub_n, lb_n, data_oe;
  logic [15:0] data_out;

  logic        p_a_req, p_a_we, p_b_req, p_b_we;
  logic [20:0] p_a_addr, p_b_addr;
  logic [7:0]  p_a_wdata, p_b_wdata;
  logic        p_a_ack, p_b_ack;
  logic [7:0]  p_a_rdata, p_b_rdata;
  logic [19:0] p_sram_addr;
  logic        p_we_n, p_oe_n, p_ub_n, p_lb_n, p_data_oe;
  logic [15:0] p_data_out;

  int n_vec = 0;
  int n_err = 0;
  bit auto_drop;

  // Per-cycle activity masks; bit i is cycle i after the request cycle.
  logic [31:0] m_oe, m_we, m_doe, m_lane, m_aack, m_back, m_poe, m_pwe, m_pack;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .rst(rst), .bus_hold(bus_hold),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .sram_addr(sram_addr), .sram_we_n(we_n), .sram_oe_n(oe_n),
    .sram_ub_n(ub_n), .sram_lb_n(lb_n), .sram_data_out(data_out),
    .sram_data_oe(data_oe), .sram_data_in(data_in)
  );

  sram_arbiter #(.ADDR_SETUP(3), .READ_WAIT(4), .WE_PULSE(1)) dut_p (
    .clk(clk), .rst(rst), .bus_hold(bus_hold),
    .a_req(p_a_req), .a_we(p_a_we), .a_addr(p_a_addr), .a_wdata(p_a_wdata),
    .a_ack(p_a_ack), .a_rdata(p_a_rdata),
    .b_req(p_b_req), .b_we(p_b_we), .b_addr(p_b_addr), .b_wdata(p_b_wdata),
    .b_ack(p_b_ack), .b_rdata(p_b_rdata),
    .sram_addr(p_sram_addr), .sram_we_n(p_we_n), .sram_oe_n(p_oe_n),
    .sram_ub_n(p_ub_n), .sram_lb_n(p_lb_n), .sram_data_out(p_data_out),
    .sram_data_oe(p_data_oe), .sram_data_in(data_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_masks();
    m_oe = '0; m_we = '0; m_doe = '0; m_lane = '0; m_aack = '0; m_back = '0;
    m_poe = '0; m_pwe = '0; m_pack = '0;
  endtask

  task automatic sample(input int i);
    @(negedge clk);
    m_oe[i]   = ~oe_n;
    m_we[i]   = ~we_n;
    m_doe[i]  = data_oe;
    m_lane[i] = ~(ub_n & lb_n);
    m_aack[i] = a_ack;
    m_back[i] = b_ack;
    m_poe[i]  = ~p_oe_n;
    m_pwe[i]  = ~p_we_n;
    m_pack[i] = p_a_ack;
    if (auto_drop) begin
      if (a_ack)   a_req   = 1'b0;
      if (b_ack)   b_req   = 1'b0;
      if (p_a_ack) p_a_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus_hold = 1'b0; auto_drop = 1'b1;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    p_a_req = 0; p_a_we = 0; p_a_addr = '0; p_a_wdata = '0;
    p_b_req = 0; p_b_we = 0; p_b_addr = '0; p_b_wdata = '0;
    data_in = '0;
    clear_masks();
    repeat (2) @(negedge clk);

    // Reset state
    check("rst strobes {we_n,oe_n,ub_n,lb_n}", {28'd0, we_n, oe_n, ub_n, lb_n}, 32'hF);
    check("rst data_oe", {31'd0, data_oe}, 32'd0);
    check("rst acks", {30'd0, a_ack, b_ack}, 32'd0);
    check("rst sram_addr", {12'd0, sram_addr}, 32'd0);
    check("rst rdata", {16'd0, a_rdata, b_rdata}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Port A lower-lane read
    a_we = 0; a_addr = 21'h08FD5; data_in = 16'h5A3C; a_req = 1;
    clear_masks();
    sample(1);
    check("rd lanes {ub_n,lb_n}", {30'd0, ub_n, lb_n}, 32'h2);
    check("rd sram_addr", {12'd0, sram_addr}, 32'h08FD5);
    for (int i = 2; i <= 8; i++) sample(i);
    check("rd oe_n low cycles", m_oe, 32'h0000_000C);
    check("rd a_ack cycle", m_aack, 32'h0000_0010);
    check("rd data_oe never", m_doe, 32'h0);
    check("rd b_ack never", m_back, 32'h0);
    check("rd a_rdata", {24'd0, a_rdata}, 32'h3C);

    // Port B upper-lane write
    b_we = 1; b_addr = 21'h100010; b_wdata = 8'hA7; b_req = 1;
    clear_masks();
    sample(1);
    check("wr lanes {ub_n,lb_n}", {30'd0, ub_n, lb_n}, 32'h1);
    check("wr sram_addr", {12'd0, sram_addr}, 32'h00010);
    check("wr data_out", {16'd0, data_out}, 32'hA7A7);
    for (int i = 2; i <= 8; i++) sample(i);
    check("wr data_oe cycles", m_doe, 32'h0000_001E);
    check("wr we_n low cycles", m_we, 32'h0000_000C);
    check("wr oe_n never", m_oe, 32'h0);
    check("wr lane cycles", m_lane, 32'h0000_001E);
    check("wr b_ack cycle", m_back, 32'h0000_0020);
    check("wr a_ack never", m_aack, 32'h0);
    check("wr b_rdata untouched", {24'd0, b_rdata}, 32'h0);

    // bus_hold raised during an A write, with B read pending
    a_we = 1; a_addr = 21'h000123; a_wdata = 8'h5C; a_req = 1;
    clear_masks();
    sample(1);
    sample(2);
    bus_hold = 1; b_we = 0; b_addr = 21'h100040; data_in = 16'hC3E1; b_req = 1;
    for (int i = 3; i <= 12; i++) sample(i);
    check("hold a_ack cycle", m_aack, 32'h0000_0020);
    check("hold we_n low cycles", m_we, 32'h0000_000C);
    check("hold data_oe cycles", m_doe, 32'h0000_001E);
    check("hold lanes then idle", m_lane, 32'h0000_001E);
    check("hold b not served", m_back, 32'h0);
    check("hold oe_n never", m_oe, 32'h0);
    bus_hold = 0;
    clear_masks();
    for (int i = 1; i <= 8; i++) sample(i);
    check("unhold b_ack cycle", m_back, 32'h0000_0010);
    check("unhold oe_n low cycles", m_oe, 32'h0000_000C);
    check("unhold b_rdata", {24'd0, b_rdata}, 32'hC3);

    // Reset in the middle of a write strobe
    a_we = 1; a_addr = 21'h000777; a_wdata = 8'h11; a_req = 1;
    clear_masks();
    sample(1);
    sample(2);
    check("midrst we_n low before rst", {31'd0, m_we[2]}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst async we_n", {31'd0, we_n}, 32'd1);
    check("midrst async data_oe", {31'd0, data_oe}, 32'd0);
    check("midrst async lanes/oe_n", {29'd0, oe_n, ub_n, lb_n}, 32'h7);
    a_req = 0;
    @(negedge clk);
    rst = 1'b0;
    clear_masks();
    for (int i = 1; i <= 6; i++) sample(i);
    check("midrst no a_ack", m_aack, 32'h0);
    check("midrst idle after", m_lane | m_we | m_oe, 32'h0);
    check("midrst rdata cleared", {16'd0, a_rdata, b_rdata}, 32'h0);

    // Contention from reset pointer: order B, A, B, A
    auto_drop = 0;
    a_we = 0; b_we = 0; a_addr = 21'h000001; b_addr = 21'h100002; data_in = 16'h1234;
    a_req = 1; b_req = 1;
    clear_masks();
    for (int i = 1; i <= 20; i++) sample(i);
    a_req = 0; b_req = 0;
    auto_drop = 1;
    check("rr a_ack cycles", m_aack, 32'h0008_0200);
    check("rr b_ack cycles", m_back, 32'h0000_4010);
    check("rr acks disjoint", m_aack & m_back, 32'h0);
    check("rr a_rdata", {24'd0, a_rdata}, 32'h34);
    check("rr b_rdata", {24'd0, b_rdata}, 32'h12);

    // Non-default timing instance
    p_a_we = 0; p_a_addr = 21'h000010; data_in = 16'h00BE; p_a_req = 1;
    clear_masks();
    for (int i = 1; i <= 10; i++) sample(i);
    check("param rd oe_n low cycles", m_poe, 32'h0000_00F0);
    check("param rd ack cycle", m_pack, 32'h0000_0100);
    check("param rd rdata", {24'd0, p_a_rdata}, 32'hBE);
    p_a_we = 1; p_a_addr = 21'h100020; p_a_wdata = 8'h3D; p_a_req = 1;
    clear_masks();
    for (int i = 1; i <= 8; i++) sample(i);
    check("param wr we_n low cycles", m_pwe, 32'h0000_0010);
    check("param wr ack cycle", m_pack, 32'h0000_0040);
    check("param wr oe_n never", m_poe, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
